// File: rtl/pwm_compare_stage_if.sv
// Duty-update handshake between a duty source and the PWM compare stage.
// Pure wiring: no latency.
// duty_ready from the stage throttles the source; data is held until accepted.
interface pwm_compare_stage_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );
endinterface

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: compares an upstream count against a period-aligned duty value.
// pwm_out and wrap_pulse are registered, one clock after the count sample.
// duty_ready drops while a shadow duty waits for the next period boundary.
module pwm_compare_stage #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count,
  pwm_compare_stage_if.slave duty_if,
  output logic             pwm_out,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] active_duty,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q;
  logic [WIDTH-1:0] active_duty_q;
  logic [WIDTH-1:0] shadow_q;
  logic             shadow_full_q;
  logic             pwm_q;
  logic             wrap_pulse_q;

  logic             wrap;
  logic             xfer;
  logic             run_now;
  logic [WIDTH-1:0] eff_duty;

  // A backwards step of the count marks a period start; this also catches an
  // upstream counter reset mid-period, while a count held at 0 never re-fires.
  assign wrap     = (count < prev_count_q);
  assign duty_if.duty_ready = (state_q == IDLE) | ~shadow_full_q;
  assign xfer     = duty_if.duty_valid & duty_if.duty_ready;
  assign eff_duty = (wrap & shadow_full_q) ? shadow_q : active_duty_q;

  // Next-state logic and the run qualifier for the compare.
  always_comb begin
    state_d = state_q;
    run_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = ARM;
      end
      ARM: begin
        run_now = wrap;
        if (!en)      state_d = IDLE;
        else if (wrap) state_d = RUN;
      end
      RUN: begin
        run_now = 1'b1;
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        run_now = ~wrap;
        if (en)        state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Count history, duty bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_count_q  <= '0;
      active_duty_q <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      pwm_q         <= 1'b0;
      wrap_pulse_q  <= 1'b0;
    end else begin
      prev_count_q <= count;
      if (state_q == IDLE) begin
        // Nothing is being generated, so a new duty can take effect at once.
        if (xfer) active_duty_q <= duty_if.duty_in;
      end else begin
        if (wrap) begin
          active_duty_q <= eff_duty;
          shadow_full_q <= 1'b0;
        end
        // A capture on the wrap cycle lands in the shadow for the next period.
        if (xfer) begin
          shadow_q      <= duty_if.duty_in;
          shadow_full_q <= 1'b1;
        end
      end
      pwm_q        <= run_now & (count < eff_duty);
      wrap_pulse_q <= wrap & (state_q != IDLE);
    end
  end

  assign pwm_out     = pwm_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign active_duty = active_duty_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Bench for pwm_compare_stage: IDLE programming table, then period-level sequences.
// Expectations per count sample are queued at drive time and compared after the edge.
// Covers alignment, shadow update, same-cycle capture, counter reset, drain, async reset.
module tb_pwm_compare_stage;

  logic       clk;
  logic       rst;
  logic       en;
  logic [5:0] count;
  logic       pwm_out;
  logic       wrap_pulse;
  logic [5:0] active_duty;
  logic       busy;

  pwm_compare_stage_if #(.WIDTH(6)) dif ();

  pwm_compare_stage #(.WIDTH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .count       (count),
    .duty_if     (dif),
    .pwm_out     (pwm_out),
    .wrap_pulse  (wrap_pulse),
    .active_duty (active_duty),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       pwm;
    logic       wp;
  } exp_t;

  typedef struct {
    logic       v;
    logic [5:0] d;
    logic       e;
    logic [5:0] c;
    logic [5:0] exp_active;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_pwm;
  } vec_t;

  exp_t  sb[$];
  vec_t  vec[4];
  int    n_chk  = 0;
  int    n_pass = 0;
  string phase  = "reset";

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s/%s @%0t: got %0d expected %0d", phase, name, $time, act, exp);
  endtask

  // One count sample: queue the expected outputs, clock it in, compare.
  task automatic tick(input logic [5:0] c, input logic e, input logic v,
                      input logic [5:0] d, input logic ep, input logic ew);
    exp_t x;
    count          = c;
    en             = e;
    dif.duty_valid = v;
    dif.duty_in    = d;
    x.pwm = ep;
    x.wp  = ew;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("pwm_out", int'(pwm_out), int'(x.pwm));
    chk("wrap_pulse", int'(wrap_pulse), int'(x.wp));
    dif.duty_valid = 1'b0;
  endtask

  // Consecutive counts lo..hi with a fixed duty; wrap_pulse expected on count 0.
  task automatic run_range(input int lo, input int hi, input logic e,
                           input int duty, input logic wp0);
    for (int c = lo; c <= hi; c++)
      tick(6'(c), e, 1'b0, 6'd0, (c < duty), wp0 && (c == 0));
  endtask

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    count          = 6'd0;
    dif.duty_valid = 1'b0;
    dif.duty_in    = 6'd0;
    #2 rst = 1'b0;
    #10;
    chk("pwm_out", int'(pwm_out), 0);
    chk("wrap_pulse", int'(wrap_pulse), 0);
    chk("active_duty", int'(active_duty), 0);
    chk("busy", int'(busy), 0);
    chk("duty_ready", int'(dif.duty_ready), 1);
    #1 rst = 1'b1;

    // IDLE programming: writes go straight to active_duty, ready never drops.
    phase = "idle_prog";
    vec[0] = '{v:1'b1, d:6'd20, e:1'b0, c:6'd1, exp_active:6'd20, exp_ready:1'b1, exp_busy:1'b0, exp_pwm:1'b0};
    vec[1] = '{v:1'b0, d:6'd33, e:1'b0, c:6'd2, exp_active:6'd20, exp_ready:1'b1, exp_busy:1'b0, exp_pwm:1'b0};
    vec[2] = '{v:1'b1, d:6'd7,  e:1'b0, c:6'd3, exp_active:6'd7,  exp_ready:1'b1, exp_busy:1'b0, exp_pwm:1'b0};
    vec[3] = '{v:1'b1, d:6'd20, e:1'b0, c:6'd4, exp_active:6'd20, exp_ready:1'b1, exp_busy:1'b0, exp_pwm:1'b0};
    for (int i = 0; i < 4; i++) begin
      count          = vec[i].c;
      en             = vec[i].e;
      dif.duty_valid = vec[i].v;
      dif.duty_in    = vec[i].d;
      @(posedge clk);
      #1;
      chk("active_duty", int'(active_duty), int'(vec[i].exp_active));
      chk("duty_ready", int'(dif.duty_ready), int'(vec[i].exp_ready));
      chk("busy", int'(busy), int'(vec[i].exp_busy));
      chk("pwm_out", int'(pwm_out), int'(vec[i].exp_pwm));
    end
    dif.duty_valid = 1'b0;

    // Enable mid-period: nothing until the count-0 sample, then duty 20.
    phase = "align";
    tick(6'd10, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("busy", int'(busy), 1);
    run_range(11, 63, 1'b1, 0, 1'b0);
    run_range(0, 63, 1'b1, 20, 1'b1);
    chk("active_duty", int'(active_duty), 20);

    // Shadow load at count 30: current period keeps 20, next uses 40.
    phase = "shadow";
    run_range(0, 29, 1'b1, 20, 1'b1);
    tick(6'd30, 1'b1, 1'b1, 6'd40, 1'b0, 1'b0);
    chk("duty_ready", int'(dif.duty_ready), 0);
    run_range(31, 34, 1'b1, 20, 1'b0);
    tick(6'd35, 1'b1, 1'b1, 6'd50, 1'b0, 1'b0);
    run_range(36, 63, 1'b1, 20, 1'b0);
    chk("active_duty", int'(active_duty), 20);
    run_range(0, 63, 1'b1, 40, 1'b1);
    chk("active_duty", int'(active_duty), 40);
    chk("duty_ready", int'(dif.duty_ready), 1);

    // Capture on the wrap sample: old duty for this period, new one after.
    phase = "same_cycle";
    tick(6'd0, 1'b1, 1'b1, 6'd10, 1'b1, 1'b1);
    chk("duty_ready", int'(dif.duty_ready), 0);
    chk("active_duty", int'(active_duty), 40);
    run_range(1, 63, 1'b1, 40, 1'b0);
    run_range(0, 63, 1'b1, 10, 1'b1);
    chk("active_duty", int'(active_duty), 10);
    chk("duty_ready", int'(dif.duty_ready), 1);

    // Upstream counter restarts at 37: treated as a period start.
    phase = "cnt_reset";
    run_range(0, 29, 1'b1, 10, 1'b1);
    tick(6'd30, 1'b1, 1'b1, 6'd25, 1'b0, 1'b0);
    run_range(31, 37, 1'b1, 10, 1'b0);
    tick(6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1);
    chk("active_duty", int'(active_duty), 25);
    run_range(1, 63, 1'b1, 25, 1'b0);

    // Drop en at count 5: period completes, then back to IDLE.
    phase = "drain";
    run_range(0, 4, 1'b1, 25, 1'b1);
    tick(6'd5, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    chk("busy", int'(busy), 1);
    run_range(6, 63, 1'b0, 25, 1'b0);
    tick(6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("busy", int'(busy), 0);
    run_range(1, 3, 1'b0, 0, 1'b0);

    // Duty 0 never goes high; duty 63 is low only at count 63.
    phase = "duty_edges";
    tick(6'd4, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
    chk("active_duty", int'(active_duty), 0);
    run_range(5, 63, 1'b1, 0, 1'b0);
    run_range(0, 9, 1'b1, 0, 1'b1);
    tick(6'd10, 1'b1, 1'b1, 6'd63, 1'b0, 1'b0);
    chk("duty_ready", int'(dif.duty_ready), 0);
    run_range(11, 63, 1'b1, 0, 1'b0);
    run_range(0, 63, 1'b1, 63, 1'b1);
    chk("active_duty", int'(active_duty), 63);

    // en drops on the wrap sample itself: the new period still runs in full.
    phase = "en_at_wrap";
    tick(6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    chk("busy", int'(busy), 1);
    run_range(1, 63, 1'b0, 63, 1'b0);
    tick(6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("busy", int'(busy), 0);

    // Async reset mid-RUN with a pending shadow value.
    phase = "async_rst";
    run_range(1, 63, 1'b1, 0, 1'b0);
    run_range(0, 4, 1'b1, 63, 1'b1);
    tick(6'd5, 1'b1, 1'b1, 6'd30, 1'b1, 1'b0);
    chk("duty_ready", int'(dif.duty_ready), 0);
    #2 rst = 1'b0;
    #1;
    chk("pwm_out", int'(pwm_out), 0);
    chk("wrap_pulse", int'(wrap_pulse), 0);
    chk("active_duty", int'(active_duty), 0);
    chk("busy", int'(busy), 0);
    chk("duty_ready", int'(dif.duty_ready), 1);
    chk("sb_empty", sb.size(), 0);
    #2 rst = 1'b1;
    run_range(6, 63, 1'b1, 0, 1'b0);
    run_range(0, 63, 1'b1, 0, 1'b1);
    chk("active_duty", int'(active_duty), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_compare_stage.md
Name: pwm_compare_stage

Overview:
- Downstream consumer of the 6-bit free-running count produced by the team's simple counter.
- Compares the incoming count against a programmable duty value and drives a registered PWM output.
- Duty updates arrive over a valid/ready handshake into a shadow register and take effect only at period boundaries (count wrap), so no glitched periods occur.
- A small FSM aligns start and stop of PWM to full periods.

Parameters:
- WIDTH, 6, width of count and duty; period = 2**WIDTH clocks.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  level; request PWM running.
- count  input  WIDTH  upstream counter value; normally increments by 1 per clk.
- duty_in  input  WIDTH  new duty value.
- duty_valid  input  1  duty_in valid this cycle.
- duty_ready  output  1  stage can accept duty_in.
- pwm_out  output  1  registered PWM output.
- wrap_pulse  output  1  one-cycle registered pulse per detected period start.
- active_duty  output  WIDTH  duty value currently in use.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; prev_count=0; active_duty=0; shadow=0; shadow_full=0; pwm_out=0; wrap_pulse=0.
  - duty_ready=1 (combinational from IDLE).
- prev_count is a register loaded with count every cycle.
- wrap = (count < prev_count), unsigned compare.
  - Covers the normal 63->0 rollover and an upstream counter reset mid-period (e.g. 37->0).
  - Count held at 0 gives no repeated wrap.
- duty_ready = (state==IDLE) | ~shadow_full. A transfer happens when duty_valid & duty_ready.
- In IDLE, a transfer writes active_duty directly on that edge. shadow stays empty.
- Outside IDLE, a transfer writes shadow and sets shadow_full. duty_ready falls the next cycle.
  - duty_valid with duty_ready low is ignored. duty_in is not captured.
- eff_duty = (wrap & shadow_full) ? shadow : active_duty.
  - On a wrap in a non-IDLE state: active_duty<=eff_duty; shadow_full<=0.
  - shadow_full here means its value before this edge. A value captured in the same cycle as a wrap goes to shadow and applies at the next wrap.
- FSM:
  - IDLE: en=1 -> ARM.
  - ARM: waits for alignment; pwm_out stays 0.
    - en=0 -> IDLE.
    - wrap -> RUN.
  - RUN: en=0 -> DRAIN.
  - DRAIN: completes the current period.
    - en=1 -> RUN.
    - wrap with en=0 -> IDLE.
    - wrap with en=1 -> RUN.
- pwm_out (registered, one-cycle latency from count):
  - pwm_out <= run_now & (count < eff_duty).
  - run_now is true in RUN, in DRAIN without wrap, and in ARM with wrap.
  - The output therefore starts exactly on the count==0 sample after alignment and ends after the last sample of the draining period.
  - duty 0 -> pwm_out constantly 0.
  - duty D -> high for D of 64 counts; maximum 63/64. 100% is not representable.
- wrap_pulse <= wrap & (state != IDLE). It is asserted in the cycle after the wrap sample.
- busy = (state != IDLE), combinational from state.
- Reset mid-operation:
  - Immediate return to IDLE with all registers cleared.
  - A pending shadow value is discarded.
- Simultaneous en=0 and wrap in RUN goes to DRAIN. The new period runs fully, then the block goes to IDLE.

Test Plan:
- Reset then program in IDLE: duty_in=20 with valid in IDLE -> active_duty=20 next cycle; duty_ready stays 1; busy=0; pwm_out=0.
- Alignment: en=1 while count=10 -> no PWM until count sample 0. Then pwm_out=1 for samples 0..19, 0 for 20..63, repeating. wrap_pulse appears once per 64 cycles.
- Shadow update: load 40 while running at count=30 -> duty_ready=0 until the wrap. Current period keeps 20; the next period is high for 40 counts; active_duty=40 after the wrap.
- Same-cycle capture and wrap (valid=1 with count 63->0, shadow empty) -> period uses the old duty. The new duty applies one period later.
- Drain: en=0 at count=5 -> the period completes (high 0..duty-1), then IDLE, busy=0, pwm_out=0. Edge cases: duty=0 -> pwm never high; duty=63 -> low only at count 63.
- Upstream counter reset at count=37 (count jumps to 0) -> treated as a wrap: wrap_pulse, shadow transfer, new period from 0. Async rst low mid-RUN -> all outputs at reset values immediately.
